// File: rtl/dp_bank_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_bank_scheduler_pkg
// Description : Shared constants and FSM state encoding for the DP bank
//               scheduler (default bank count, bank index width, traceback
//               request pulse length, pulse counter width).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package dp_bank_scheduler_pkg;

    localparam int c_NUM_BANKS_DEF = 2;
    localparam int c_BANK_W_DEF    = $clog2(c_NUM_BANKS_DEF);
    localparam int c_TB_PULSE_DEF  = 3;
    // Pulse length is limited to 1..7, so three bits always suffice.
    localparam int c_TB_CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FULL = 2'b10
    } sched_state_t;

endpackage : dp_bank_scheduler_pkg
`default_nettype wire

// File: rtl/dp_bank_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : dp_bank_scheduler_if
// Description : Host / traceback side bundle of the DP bank scheduler.
//   new_seq     host -> sched  level, rising edge = sequence boundary
//   tb_busy     tb   -> sched  traceback engine busy
//   tb_done     tb   -> sched  one-cycle pulse, tb_bank released
//   active_bank sched -> dp    bank receiving DP computation
//   compute_en  sched -> dp    active_bank may compute
//   stall       sched -> host  no free bank, hold input
//   tb_valid    sched -> tb    traceback request pulse
//   tb_bank     sched -> tb    bank to trace
//   pending_cnt sched -> obs   banks queued, not yet dispatched
//   overflow    sched -> obs   sticky, boundary seen while stalled
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface dp_bank_scheduler_if
    import dp_bank_scheduler_pkg::*;
#(
    parameter int NUM_BANKS = c_NUM_BANKS_DEF,
    parameter int BANK_W    = $clog2(NUM_BANKS)
);
    logic              new_seq;
    logic              tb_busy;
    logic              tb_done;
    logic [BANK_W-1:0] active_bank;
    logic              compute_en;
    logic              stall;
    logic              tb_valid;
    logic [BANK_W-1:0] tb_bank;
    logic [BANK_W:0]   pending_cnt;
    logic              overflow;

    // Scheduler side.
    modport slave (
        input  new_seq, tb_busy, tb_done,
        output active_bank, compute_en, stall, tb_valid, tb_bank,
               pending_cnt, overflow
    );

    // Host / traceback side.
    modport master (
        output new_seq, tb_busy, tb_done,
        input  active_bank, compute_en, stall, tb_valid, tb_bank,
               pending_cnt, overflow
    );
endinterface : dp_bank_scheduler_if
`default_nettype wire

// File: rtl/dp_bank_scheduler_bank_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dp_bank_scheduler_bank_fifo
// Description : Circular queue of finished bank indices awaiting traceback.
//   clk, reset_i  clock, asynchronous active-low reset (empties the queue)
//   push/push_data enqueue (ignored when full)
//   pop           dequeue head (ignored when empty)
//   head          current head entry
//   count         number of entries held
//   empty         count == 0
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module dp_bank_scheduler_bank_fifo
    import dp_bank_scheduler_pkg::*;
#(
    parameter int WIDTH = c_BANK_W_DEF,
    parameter int DEPTH = c_NUM_BANKS_DEF,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  wire logic             clk,
    input  wire logic             reset_i,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] head,
    output logic      [CNT_W-1:0] count,
    output logic                  empty
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push_ok = push && (r_count != CNT_W'(DEPTH));
    assign w_pop_ok  = pop  && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop_ok)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
endmodule : dp_bank_scheduler_bank_fifo
`default_nettype wire

// File: rtl/dp_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dp_bank_scheduler
// Description : Round-robin scheduler for NUM_BANKS DP compute banks feeding
//               a single traceback engine. Finished banks are queued, handed
//               to traceback one at a time, and the host is stalled while no
//               bank is free.
//   clk      clock
//   reset_i  asynchronous active-low reset, clears all state and outputs
//   bus      dp_bank_scheduler_if.slave (host / traceback handshakes)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module dp_bank_scheduler
    import dp_bank_scheduler_pkg::*;
#(
    parameter int NUM_BANKS = c_NUM_BANKS_DEF,
    parameter int BANK_W    = $clog2(NUM_BANKS),
    parameter int TB_PULSE  = c_TB_PULSE_DEF
) (
    input  wire logic            clk,
    input  wire logic            reset_i,
    dp_bank_scheduler_if.slave   bus
);
    sched_state_t          r_state, w_state_nxt;
    logic                  r_nsq, r_nsq2, w_seq_done;
    logic [BANK_W-1:0]     r_active, w_active_nxt;
    logic [NUM_BANKS-1:0]  r_occ, w_occ_nxt, w_occ_rel, w_rel_mask;
    logic                  r_in_tb;
    logic [BANK_W-1:0]     r_tb_bank;
    logic                  r_tb_valid;
    logic [c_TB_CNT_W-1:0] r_tb_cnt;
    logic                  r_overflow, w_overflow_nxt;
    logic                  r_compute_en, r_stall;
    logic                  w_push, w_dispatch, w_release;
    logic [BANK_W:0]       w_pick;
    logic [BANK_W-1:0]     w_head;
    logic [BANK_W:0]       w_count;
    logic                  w_empty;

    // First free bank scanning circularly from start+1. MSB flags a hit.
    // Scanning the offsets downwards lets the nearest bank win last.
    function automatic logic [BANK_W:0] find_free(
        input logic [NUM_BANKS-1:0] occ_v,
        input logic [BANK_W-1:0]    start
    );
        logic [BANK_W:0] res;
        res = '0;
        for (int i = NUM_BANKS; i >= 1; i--) begin
            int idx;
            idx = (int'(start) + i) % NUM_BANKS;
            if (!occ_v[idx[BANK_W-1:0]]) res = {1'b1, idx[BANK_W-1:0]};
        end
        return res;
    endfunction

    assign w_seq_done = r_nsq & ~r_nsq2;

    dp_bank_scheduler_bank_fifo #(
        .WIDTH (BANK_W),
        .DEPTH (NUM_BANKS)
    ) u_bank_fifo (
        .clk       (clk),
        .reset_i   (reset_i),
        .push      (w_push),
        .push_data (r_active),
        .pop       (w_dispatch),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_release  = bus.tb_done & r_in_tb;
        w_rel_mask = '0;
        if (w_release) w_rel_mask[r_tb_bank] = 1'b1;
        // Release lands before the free search so a bank freed this cycle
        // can be picked as the next active bank in the same cycle.
        w_occ_rel  = r_occ & ~w_rel_mask;
        w_pick     = find_free(w_occ_rel, r_active);
        w_dispatch = !w_empty && !r_in_tb && !bus.tb_busy && !r_tb_valid;

        w_state_nxt    = r_state;
        w_active_nxt   = r_active;
        w_occ_nxt      = w_occ_rel;
        w_push         = 1'b0;
        w_overflow_nxt = r_overflow;

        case (r_state)
            ST_IDLE: begin
                // Nothing computed yet, so no handoff on the first boundary.
                if (w_seq_done) begin
                    w_state_nxt  = ST_RUN;
                    w_active_nxt = '0;
                    w_occ_nxt[0] = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_seq_done) begin
                    w_push = 1'b1;
                    if (w_pick[BANK_W]) begin
                        w_active_nxt                     = w_pick[BANK_W-1:0];
                        w_occ_nxt[w_pick[BANK_W-1:0]]    = 1'b1;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                // A free bank here can only come from a release this cycle;
                // a coincident boundary is then not a stalled one.
                if (w_pick[BANK_W]) begin
                    w_state_nxt                   = ST_RUN;
                    w_active_nxt                  = w_pick[BANK_W-1:0];
                    w_occ_nxt[w_pick[BANK_W-1:0]] = 1'b1;
                end else if (w_seq_done) begin
                    w_overflow_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_nsq        <= 1'b0;
            r_nsq2       <= 1'b0;
            r_active     <= '0;
            r_occ        <= '0;
            r_in_tb      <= 1'b0;
            r_tb_bank    <= '0;
            r_tb_valid   <= 1'b0;
            r_tb_cnt     <= '0;
            r_overflow   <= 1'b0;
            r_compute_en <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            r_nsq        <= bus.new_seq;
            r_nsq2       <= r_nsq;
            r_active     <= w_active_nxt;
            r_occ        <= w_occ_nxt;
            r_overflow   <= w_overflow_nxt;
            r_compute_en <= (w_state_nxt == ST_RUN);
            r_stall      <= (w_state_nxt == ST_FULL);
            // Dispatch needs !r_in_tb and release needs r_in_tb: exclusive.
            if (w_dispatch) begin
                r_tb_bank  <= w_head;
                r_in_tb    <= 1'b1;
                r_tb_valid <= 1'b1;
                r_tb_cnt   <= c_TB_CNT_W'(TB_PULSE - 1);
            end else begin
                if (w_release) r_in_tb <= 1'b0;
                if (r_tb_valid) begin
                    if (r_tb_cnt == '0) r_tb_valid <= 1'b0;
                    else                r_tb_cnt   <= r_tb_cnt - 1'b1;
                end
            end
        end
    end

    assign bus.active_bank = r_active;
    assign bus.compute_en  = r_compute_en;
    assign bus.stall       = r_stall;
    assign bus.tb_valid    = r_tb_valid;
    assign bus.tb_bank     = r_tb_bank;
    assign bus.pending_cnt = w_count;
    assign bus.overflow    = r_overflow;
endmodule : dp_bank_scheduler
`default_nettype wire

// File: tb/tb_dp_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_bank_scheduler
// Description : Bench for dp_bank_scheduler with a 2-bank and a 3-bank
//               instance, each tracked by a queue-based behavioural model,
//               plus directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_bank_scheduler;
    localparam int TBP = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic ns[2], busy[2], done[2];
    logic [3:0] o_act[2], o_tbb[2], o_pend[2];
    logic o_ce[2], o_stall[2], o_valid[2], o_ovf[2];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int NB = k + 2;

        dp_bank_scheduler_if #(.NUM_BANKS(NB)) u_if ();

        assign u_if.new_seq = ns[k];
        assign u_if.tb_busy = busy[k];
        assign u_if.tb_done = done[k];

        dp_bank_scheduler #(.NUM_BANKS(NB), .TB_PULSE(TBP)) u_dut (
            .clk     (clk),
            .reset_i (rst_n),
            .bus     (u_if.slave)
        );

        assign o_act[k]   = 4'(u_if.active_bank);
        assign o_tbb[k]   = 4'(u_if.tb_bank);
        assign o_pend[k]  = 4'(u_if.pending_cnt);
        assign o_ce[k]    = u_if.compute_en;
        assign o_stall[k] = u_if.stall;
        assign o_valid[k] = u_if.tb_valid;
        assign o_ovf[k]   = u_if.overflow;

        // Model: mode 0 idle, 1 running, 2 stalled. A bank is busy when it
        // is the current active bank, sits in the queue, or is in traceback.
        int m_q[$];
        int m_mode, m_act, m_tbb, m_pl;
        bit m_in_tb, m_ovf, m_s1, m_s2;

        function automatic void m_reset();
            m_q.delete();
            m_mode = 0; m_act = 0; m_tbb = 0; m_pl = 0;
            m_in_tb = 0; m_ovf = 0; m_s1 = 0; m_s2 = 0;
        endfunction

        function automatic bit is_busy(input int b);
            if (m_mode != 0 && b == m_act) return 1'b1;
            foreach (m_q[j]) if (m_q[j] == b) return 1'b1;
            if (m_in_tb && b == m_tbb) return 1'b1;
            return 1'b0;
        endfunction

        function automatic int next_free(input int from);
            for (int i = 1; i <= NB; i++) begin
                if (!is_busy((from + i) % NB)) return (from + i) % NB;
            end
            return -1;
        endfunction

        function automatic void m_step();
            bit bnd, disp;
            int nf;
            // Boundary acted on = rising edge between the two previous samples.
            bnd  = m_s1 && !m_s2;
            m_s2 = m_s1;
            m_s1 = ns[k];
            disp = (m_q.size() != 0) && !m_in_tb && !busy[k] && (m_pl == 0);
            if (m_pl > 0) m_pl--;
            if (done[k] && m_in_tb) m_in_tb = 0;
            case (m_mode)
                0: if (bnd) begin m_mode = 1; m_act = 0; end
                1: if (bnd) begin
                    m_q.push_back(m_act);
                    nf = next_free(m_act);
                    if (nf >= 0) m_act = nf; else m_mode = 2;
                end
                default: begin
                    nf = next_free(m_act);
                    if (nf >= 0) begin m_act = nf; m_mode = 1; end
                    else if (bnd) m_ovf = 1;
                end
            endcase
            if (disp) begin
                m_tbb   = m_q.pop_front();
                m_in_tb = 1;
                m_pl    = TBP;
            end
        endfunction

        initial begin
            m_reset();
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) m_reset();
                else        m_step();
            end
        end

        always @(negedge clk) begin
            chk($sformatf("i%0d active_bank", k), int'(o_act[k]), m_act);
            chk($sformatf("i%0d compute_en", k),  int'(o_ce[k]), int'(m_mode == 1));
            chk($sformatf("i%0d stall", k),       int'(o_stall[k]), int'(m_mode == 2));
            chk($sformatf("i%0d tb_valid", k),    int'(o_valid[k]), int'(m_pl > 0));
            chk($sformatf("i%0d tb_bank", k),     int'(o_tbb[k]), m_tbb);
            chk($sformatf("i%0d pending_cnt", k), int'(o_pend[k]), m_q.size());
            chk($sformatf("i%0d overflow", k),    int'(o_ovf[k]), int'(m_ovf));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // One full new_seq pulse; returns how many sampled cycles had tb_valid.
    task automatic seq_edge(input int k, output int vcnt);
        vcnt = 0;
        ns[k] = 1'b1;
        repeat (3) begin step(); vcnt += int'(o_valid[k]); end
        ns[k] = 1'b0;
        repeat (5) begin step(); vcnt += int'(o_valid[k]); end
    endtask

    task automatic pulse_done(input int k);
        done[k] = 1'b1;
        step();
        done[k] = 1'b0;
        step();
    endtask

    task automatic hard_reset();
        for (int k = 0; k < 2; k++) begin
            ns[k] = 1'b0; busy[k] = 1'b0; done[k] = 1'b0;
        end
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        int v;
        int w;
        for (int k = 0; k < 2; k++) begin
            ns[k] = 1'b0; busy[k] = 1'b0; done[k] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        step(2);
        for (int k = 0; k < 2; k++) begin
            chk("reset active_bank", int'(o_act[k]), 0);
            chk("reset compute_en", int'(o_ce[k]), 0);
            chk("reset pending_cnt", int'(o_pend[k]), 0);
        end
        rst_n = 1'b1;
        step(2);

        // Reset in the middle of a run with one bank queued.
        busy[0] = 1'b1;
        seq_edge(0, v);
        seq_edge(0, v);
        chk("R pending before reset", int'(o_pend[0]), 1);
        chk("R active before reset", int'(o_act[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("R async active_bank", int'(o_act[0]), 0);
        chk("R async compute_en", int'(o_ce[0]), 0);
        chk("R async pending_cnt", int'(o_pend[0]), 0);
        busy[0] = 1'b0;
        step();
        rst_n = 1'b1;
        step(2);
        chk("R idle compute_en", int'(o_ce[0]), 0);

        // Ping-pong with immediate traceback.
        seq_edge(0, v);
        chk("A first active", int'(o_act[0]), 0);
        chk("A first compute_en", int'(o_ce[0]), 1);
        seq_edge(0, v);
        chk("A pulse length", v, 3);
        chk("A tb_bank 0", int'(o_tbb[0]), 0);
        chk("A active 1", int'(o_act[0]), 1);
        pulse_done(0);
        seq_edge(0, v);
        chk("A tb_bank 1", int'(o_tbb[0]), 1);
        chk("A active back 0", int'(o_act[0]), 0);
        chk("A second pulse length", v, 3);
        hard_reset();

        // Stall and overflow with no release, then recovery.
        repeat (3) seq_edge(0, v);
        chk("B stall", int'(o_stall[0]), 1);
        chk("B compute_en off", int'(o_ce[0]), 0);
        chk("B pending", int'(o_pend[0]), 1);
        seq_edge(0, v);
        chk("B overflow", int'(o_ovf[0]), 1);
        pulse_done(0);
        step(3);
        chk("B stall cleared", int'(o_stall[0]), 0);
        chk("B active 0", int'(o_act[0]), 0);
        chk("B tb_bank 1", int'(o_tbb[0]), 1);
        chk("B overflow sticky", int'(o_ovf[0]), 1);
        hard_reset();

        // Release coinciding with a boundary while stalled.
        repeat (3) seq_edge(0, v);
        chk("E stalled", int'(o_stall[0]), 1);
        ns[0] = 1'b1;
        step();
        done[0] = 1'b1;
        step();
        done[0] = 1'b0;
        step(4);
        ns[0] = 1'b0;
        step(4);
        chk("E active 0", int'(o_act[0]), 0);
        chk("E compute_en", int'(o_ce[0]), 1);
        chk("E stall", int'(o_stall[0]), 0);
        chk("E no overflow", int'(o_ovf[0]), 0);
        hard_reset();

        // Stray tb_done and a long-held new_seq level.
        pulse_done(0);
        chk("H stray idle compute_en", int'(o_ce[0]), 0);
        chk("H stray idle tb_valid", int'(o_valid[0]), 0);
        seq_edge(0, v);
        pulse_done(0);
        chk("H stray run active", int'(o_act[0]), 0);
        chk("H stray run compute_en", int'(o_ce[0]), 1);
        ns[0] = 1'b1;
        step(20);
        ns[0] = 1'b0;
        step(5);
        chk("H held once active", int'(o_act[0]), 1);
        chk("H held once stall", int'(o_stall[0]), 0);
        chk("H held once tb_bank", int'(o_tbb[0]), 0);
        hard_reset();

        // Three banks with traceback held busy, then in-order dispatch.
        busy[1] = 1'b1;
        repeat (3) seq_edge(1, v);
        chk("C pending 2", int'(o_pend[1]), 2);
        chk("C active 2", int'(o_act[1]), 2);
        chk("C no request while busy", v, 0);
        busy[1] = 1'b0;
        step(2);
        chk("C tb_bank 0", int'(o_tbb[1]), 0);
        chk("C pending 1", int'(o_pend[1]), 1);
        chk("C tb_valid", int'(o_valid[1]), 1);
        w = 0;
        while (o_valid[1] && w < 20) begin step(); w++; end
        chk("C tb_valid drop", int'(o_valid[1]), 0);
        pulse_done(1);
        step(3);
        chk("C tb_bank 1", int'(o_tbb[1]), 1);
        chk("C pending 0", int'(o_pend[1]), 0);
        hard_reset();

        // Randomised traffic on both instances.
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(7) == 0) ns[k] = ~ns[k];
                busy[k] = ($urandom_range(3) == 0);
                done[k] = ($urandom_range(5) == 0);
            end
            if (i == 2000) begin
                #1 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule : tb_dp_bank_scheduler
`default_nettype wire
